// File: rtl/csr_pkg.sv
// Shared definitions for the trap/return sequencer: CSR indices, mstatus
// bit positions, sequencer states and the mstatus update functions.
package csr_pkg;

  localparam logic [2:0] MSTATUS = 3'd0;
  localparam logic [2:0] MTVEC   = 3'd1;
  localparam logic [2:0] MEPC    = 3'd2;
  localparam logic [2:0] MCAUSE  = 3'd3;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;

  // mstatus helpers operate on the widest supported XLEN
  localparam int FN_W = 64;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_T_EPC    = 3'd1,
    S_T_CAUSE  = 3'd2,
    S_T_STATUS = 3'd3,
    S_T_JUMP   = 3'd4,
    S_M_STATUS = 3'd5,
    S_M_JUMP   = 3'd6
  } state_e;

  function automatic logic [FN_W-1:0] trap_mstatus(input logic [FN_W-1:0] s);
    logic [FN_W-1:0] r;
    r                = s;
    r[MPIE_BIT]      = s[MIE_BIT];
    r[MIE_BIT]       = 1'b0;
    r[MPP_HI:MPP_LO] = 2'b11;
    return r;
  endfunction

  // M-only core: MPP always returns to machine mode
  function automatic logic [FN_W-1:0] mret_mstatus(input logic [FN_W-1:0] s);
    logic [FN_W-1:0] r;
    r                = s;
    r[MIE_BIT]       = s[MPIE_BIT];
    r[MPIE_BIT]      = 1'b1;
    r[MPP_HI:MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Sequences trap entry and mret into single-port CSR writes plus a PC redirect.
// Optional build macro CSR_VECTORED_TRAP_EN enables vectored mtvec mode.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int CAUSE_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               trap_req,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic               mret_req,
  input  logic               inst_wen,
  input  logic [2:0]         inst_waddr,
  input  logic [XLEN-1:0]    inst_wdata,
  input  logic [2:0]         inst_raddr,
  output logic [XLEN-1:0]    inst_rdata,
  output logic               busy,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [2:0]         csr_raddr,
  input  logic [XLEN-1:0]    csr_rdata,
  output logic               csr_wen,
  output logic [2:0]         csr_waddr,
  output logic [XLEN-1:0]    csr_wdata
);

  state_e             r_state;
  state_e             w_next;
  logic [XLEN-1:0]    r_pc;
  logic [CAUSE_W-1:0] r_cause;
  logic               w_wen;
  logic               w_redirect;
  logic [FN_W-1:0]    w_status_in;
  logic [XLEN-1:0]    w_base;
  logic [XLEN-1:0]    w_trap_target;

  assign w_status_in = FN_W'(csr_rdata);
  assign w_base      = {csr_rdata[XLEN-1:2], 2'b00};

`ifdef CSR_VECTORED_TRAP_EN
  assign w_trap_target = (csr_rdata[1:0] == 2'b01)
                       ? w_base + (XLEN'(r_cause) << 2)
                       : w_base;
`else
  assign w_trap_target = w_base;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cause <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && trap_req) begin
        r_pc    <= trap_pc;
        r_cause <= trap_cause;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wen       = 1'b0;
    w_redirect  = 1'b0;
    csr_waddr   = 3'd0;
    csr_wdata   = '0;
    csr_raddr   = 3'd0;
    inst_rdata  = '0;
    redirect_pc = '0;
    case (r_state)
      S_IDLE: begin
        csr_raddr  = inst_raddr;
        inst_rdata = csr_rdata;
        if (trap_req) begin
          w_next = S_T_EPC;
        end else if (mret_req) begin
          w_next = S_M_STATUS;
        end else begin
          w_wen     = inst_wen;
          csr_waddr = inst_waddr;
          csr_wdata = inst_wdata;
        end
      end
      S_T_EPC: begin
        w_wen     = 1'b1;
        csr_waddr = MEPC;
        csr_wdata = r_pc;
        w_next    = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        w_wen     = 1'b1;
        csr_waddr = MCAUSE;
        csr_wdata = XLEN'(r_cause);
        w_next    = S_T_STATUS;
      end
      S_T_STATUS: begin
        csr_raddr = MSTATUS;
        w_wen     = 1'b1;
        csr_waddr = MSTATUS;
        csr_wdata = XLEN'(trap_mstatus(w_status_in));
        w_next    = S_T_JUMP;
      end
      S_T_JUMP: begin
        csr_raddr   = MTVEC;
        w_redirect  = 1'b1;
        redirect_pc = w_trap_target;
        w_next      = S_IDLE;
      end
      S_M_STATUS: begin
        csr_raddr = MSTATUS;
        w_wen     = 1'b1;
        csr_waddr = MSTATUS;
        csr_wdata = XLEN'(mret_mstatus(w_status_in));
        w_next    = S_M_JUMP;
      end
      S_M_JUMP: begin
        csr_raddr   = MEPC;
        w_redirect  = 1'b1;
        redirect_pc = csr_rdata;
        w_next      = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // A reset cycle must neither commit a CSR write nor emit a redirect
  assign csr_wen        = w_wen & ~reset;
  assign redirect_valid = w_redirect & ~reset;
  assign busy           = (r_state != S_IDLE) | trap_req | mret_req;

endmodule
